mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: MEM pipeline register, req/ack data-memory port, big-endian lane steering and load extension.
// Optional MEM_TIMEOUT_EN adds an ack timeout that completes the access with bus_err.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dMemWr,
  input  logic        dMemToReg,
  input  logic        dRegWrite,
  input  logic        dJal,
  input  logic        dLoadext,
  input  logic [1:0]  dDsize,
  input  logic [1:0]  dFPoint,
  input  logic [31:0] dALUout,
  input  logic [31:0] dBusB,
  input  logic [4:0]  dRw,
  input  logic [31:0] dDelayslot2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        MemtoReg,
  output logic        RegWr,
  output logic        Jal,
  output logic [1:0]  FPoint,
  output logic [4:0]  Rw,
  output logic [31:0] ALUout,
  output logic [31:0] MemData,
  output logic [31:0] Delayslot2,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic        memWrReg, memtoRegReg, regWrReg, jalReg, loadextReg, misalignReg;
  logic [1:0]  dsizeReg, fpointReg;
  logic [4:0]  rwReg;
  logic [31:0] aluReg, ds2Reg, memDataReg, wdataReg;
  logic [3:0]  beReg;

  logic        dMemOp, dMisalign;
  logic [3:0]  dBe;
  logic [31:0] dWdata;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadExt;

  // Alignment and lane steering are resolved from the incoming op so they can be registered.
  always_comb begin
    dMemOp    = dMemWr | dMemToReg;
    dMisalign = 1'b0;
    dBe       = 4'b1111;
    dWdata    = dBusB;
    case (dDsize)
      2'b10: begin
        dBe    = 4'b1000 >> dALUout[1:0];
        dWdata = {4{dBusB[7:0]}};
      end
      2'b01: begin
        dMisalign = dMemOp & dALUout[0];
        dBe       = dALUout[1] ? 4'b0011 : 4'b1100;
        dWdata    = {2{dBusB[15:0]}};
      end
      default: dMisalign = dMemOp & (|dALUout[1:0]);
    endcase
  end

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    case (aluReg[1:0])
      2'b00:   laneByte = dmem_rdata[31:24];
      2'b01:   laneByte = dmem_rdata[23:16];
      2'b10:   laneByte = dmem_rdata[15:8];
      default: laneByte = dmem_rdata[7:0];
    endcase
    laneHalf = aluReg[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    case (dsizeReg)
      2'b10:   loadExt = {{24{loadextReg & laneByte[7]}}, laneByte};
      2'b01:   loadExt = {{16{loadextReg & laneHalf[15]}}, laneHalf};
      default: loadExt = dmem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [31:0] toCnt;
  logic        busErrReg;
`else
  logic        unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      memWrReg    <= 1'b0;
      memtoRegReg <= 1'b0;
      regWrReg    <= 1'b0;
      jalReg      <= 1'b0;
      loadextReg  <= 1'b0;
      misalignReg <= 1'b0;
      dsizeReg    <= 2'b00;
      fpointReg   <= 2'b00;
      rwReg       <= 5'd0;
      aluReg      <= 32'd0;
      ds2Reg      <= 32'd0;
      memDataReg  <= 32'd0;
      wdataReg    <= 32'd0;
      beReg       <= 4'b0000;
`ifdef MEM_TIMEOUT_EN
      toCnt       <= 32'd0;
      busErrReg   <= 1'b0;
`endif
    end else if (state == REQ) begin
      if (dmem_ack) begin
        if (memtoRegReg) memDataReg <= loadExt;
        state <= DONE;
      end
`ifdef MEM_TIMEOUT_EN
      else if (toCnt == 32'(TIMEOUT_CYCLES - 1)) begin
        state     <= DONE;
        regWrReg  <= 1'b0;
        busErrReg <= 1'b1;
      end else begin
        toCnt <= toCnt + 32'd1;
      end
`endif
    end else begin
      // IDLE and DONE both accept the next instruction.
      memWrReg    <= dMemWr;
      memtoRegReg <= dMemToReg;
      regWrReg    <= dRegWrite & ~dMisalign;
      jalReg      <= dJal;
      loadextReg  <= dLoadext;
      misalignReg <= dMisalign;
      dsizeReg    <= dDsize;
      fpointReg   <= dFPoint;
      rwReg       <= dRw;
      aluReg      <= dALUout;
      ds2Reg      <= dDelayslot2;
      wdataReg    <= dWdata;
      beReg       <= dBe;
      state       <= (dMemOp & ~dMisalign) ? REQ : IDLE;
`ifdef MEM_TIMEOUT_EN
      toCnt       <= 32'd0;
      busErrReg   <= 1'b0;
`endif
    end
  end

  assign stall      = (state == REQ);
  assign dmem_req   = (state == REQ);
  assign dmem_we    = (state == REQ) & memWrReg;
  assign dmem_addr  = {aluReg[31:2], 2'b00};
  assign dmem_be    = beReg;
  assign dmem_wdata = wdataReg;
  assign MemtoReg   = memtoRegReg;
  assign RegWr      = regWrReg;
  assign Jal        = jalReg;
  assign FPoint     = fpointReg;
  assign Rw         = rwReg;
  assign ALUout     = aluReg;
  assign MemData    = memDataReg;
  assign Delayslot2 = ds2Reg;
  assign misalign   = misalignReg;
`ifdef MEM_TIMEOUT_EN
  assign bus_err    = busErrReg;
`else
  assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: driver pushes expectations, a monitor pops them when
// the stage presents a result, and a memory responder checks the port and returns planned data.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dMemWr = 0, dMemToReg = 0, dRegWrite = 0, dJal = 0, dLoadext = 0;
  logic [1:0]  dDsize = 0, dFPoint = 0;
  logic [31:0] dALUout = 0, dBusB = 0, dDelayslot2 = 0;
  logic [4:0]  dRw = 0;
  logic [31:0] dmem_rdata = 0;
  logic        dmem_ack = 0;
  logic        dmem_req, dmem_we, stall, MemtoReg, RegWr, Jal, misalign, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, ALUout, MemData, Delayslot2;
  logic [3:0]  dmem_be;
  logic [1:0]  FPoint;
  logic [4:0]  Rw;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dMemWr(dMemWr), .dMemToReg(dMemToReg), .dRegWrite(dRegWrite), .dJal(dJal), .dLoadext(dLoadext),
    .dDsize(dDsize), .dFPoint(dFPoint), .dALUout(dALUout), .dBusB(dBusB), .dRw(dRw),
    .dDelayslot2(dDelayslot2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .MemtoReg(MemtoReg), .RegWr(RegWr), .Jal(Jal), .FPoint(FPoint), .Rw(Rw),
    .ALUout(ALUout), .MemData(MemData), .Delayslot2(Delayslot2), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic regWr, memtoReg, jal, mis, busErr;
    logic [1:0] fp;
    logic [4:0] rw;
    logic [31:0] alu, memData, ds2;
    int stallCycles;
  } exp_t;

  typedef struct {
    int delay;
    logic we;
    logic [3:0] be;
    logic [31:0] addr, wdata, rdata;
  } plan_t;

  exp_t  expQ[$];
  plan_t planQ[$];
  int tests = 0, errors = 0, txCount = 0;
  logic [31:0] modelMemData = 0;
  bit monOn = 0, respOn = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access width in bytes, first lane (0 = MSB), lane masks, extraction.
  function automatic int bytesOf(input logic [1:0] sz);
    return (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int firstLane(input logic [1:0] sz, input logic [1:0] a);
    int n = bytesOf(sz);
    return (int'(a) / n) * n;
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m = 4'b0000;
    int k = firstLane(sz, a);
    for (int i = 0; i < bytesOf(sz); i++) m[3 - k - i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] b);
    logic [31:0] w = 0;
    int n = bytesOf(sz);
    for (int i = 0; i < 4; i++) w = (w << 8) | ((b >> (8 * ((n - 1) - (i % n)))) & 32'hFF);
    return w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic [1:0] a,
                                            input bit ext, input logic [31:0] rd);
    int n = bytesOf(sz);
    int k = firstLane(sz, a);
    logic [31:0] mask, v;
    if (n == 4) return rd;
    mask = (n == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * (4 - k - n))) & mask;
    if (ext && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic issue(input bit wr, input bit ld, input bit regw, input bit jal, input bit ext,
                       input logic [1:0] sz, input logic [1:0] fp, input logic [31:0] alu,
                       input logic [31:0] busb, input logic [4:0] rd, input logic [31:0] ds2,
                       input int delay, input logic [31:0] rdata);
    exp_t e;
    plan_t p;
    bit memOp, mis, aligned, timeout;
    int w = 0;
    @(negedge clk);
    while (stall !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      tests++;
      errors++;
      $display("FAIL driver_wait: stall got %b expected 0 within 200 cycles", stall);
    end
    dMemWr = wr; dMemToReg = ld; dRegWrite = regw; dJal = jal; dLoadext = ext;
    dDsize = sz; dFPoint = fp; dALUout = alu; dBusB = busb; dRw = rd; dDelayslot2 = ds2;

    memOp = wr | ld;
    mis = memOp && (((sz == 2'b01) && alu[0]) || ((bytesOf(sz) == 4) && (alu[1:0] != 2'b00)));
    aligned = memOp && !mis;
    timeout = aligned && (delay == 0);
    if (aligned && ld && !timeout) modelMemData = modelLoad(sz, alu[1:0], ext, rdata);
    e.regWr = regw && !mis && !timeout;
    e.memtoReg = ld; e.jal = jal; e.mis = mis; e.busErr = timeout;
    e.fp = fp; e.rw = rd; e.alu = alu; e.ds2 = ds2; e.memData = modelMemData;
    e.stallCycles = aligned ? (timeout ? TO : delay) : 0;
    p.delay = delay; p.we = wr; p.be = modelBe(sz, alu[1:0]);
    p.addr = alu & 32'hFFFF_FFFC; p.wdata = modelWdata(sz, busb); p.rdata = rdata;
    @(posedge clk);
    expQ.push_back(e);
    if (aligned) planQ.push_back(p);
  endtask

  // Monitor: a result is presented on the first non-stalled cycle after its load edge.
  initial begin
    int stallCnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!monOn) stallCnt = 0;
      else if (stall) stallCnt++;
      else if (expQ.size() > 0) begin
        e = expQ.pop_front();
        txCount++;
        $display("[TB] tx %0d rw=%0d alu=%h memdata=%h stall_cycles=%0d", txCount, Rw, ALUout, MemData, stallCnt);
        chk("RegWr", RegWr, e.regWr);
        chk("MemtoReg", MemtoReg, e.memtoReg);
        chk("Jal", Jal, e.jal);
        chk("FPoint", FPoint, e.fp);
        chk("Rw", Rw, e.rw);
        chk("ALUout", ALUout, e.alu);
        chk("MemData", MemData, e.memData);
        chk("Delayslot2", Delayslot2, e.ds2);
        chk("misalign", misalign, e.mis);
        chk("bus_err", bus_err, e.busErr);
        chk("dmem_req_idle", dmem_req, 0);
        chk("stall_cycles", stallCnt, e.stallCycles);
        stallCnt = 0;
      end
    end
  end

  // Memory responder: checks the request on its first cycle, acks after the planned delay.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (!respOn) begin
        cnt = 0;
        planQ.delete();
      end else if (dmem_req) begin
        if (planQ.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_req: dmem_req got 1 expected 0");
          dmem_ack = 0;
        end else begin
          if (cnt == 0) begin
            chk("dmem_addr", dmem_addr, planQ[0].addr);
            chk("dmem_be", dmem_be, planQ[0].be);
            chk("dmem_we", dmem_we, planQ[0].we);
            if (planQ[0].we) chk("dmem_wdata", dmem_wdata, planQ[0].wdata);
          end
          cnt++;
          if (planQ[0].delay != 0 && cnt == planQ[0].delay) begin
            dmem_ack = 1;
            dmem_rdata = planQ[0].rdata;
            void'(planQ.pop_front());
            cnt = 0;
          end else begin
            dmem_ack = 0;
            dmem_rdata = $urandom;
          end
        end
      end else begin
        if (cnt != 0) begin
          void'(planQ.pop_front());
          cnt = 0;
        end
        dmem_ack = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  task automatic checkAllZero(input string tag);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_be"}, dmem_be, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_ctl"}, {MemtoReg, RegWr, Jal, misalign, bus_err, FPoint, Rw}, 0);
    chk({tag, "_ALUout"}, ALUout, 0);
    chk({tag, "_MemData"}, MemData, 0);
    chk({tag, "_Delayslot2"}, Delayslot2, 0);
  endtask

  initial begin
    bit wr, ld;
    int kind, dly;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1;
    monOn = 1;

    issue(0, 0, 1, 0, 0, 2'b00, 2'b01, 32'h1234, 32'h0, 5'd5, 32'h40, 1, 0);
    issue(0, 1, 1, 0, 1, 2'b10, 2'b00, 32'h103, 32'h0, 5'd7, 32'h44, 3, 32'h112233F0);
    issue(0, 1, 1, 0, 0, 2'b10, 2'b00, 32'h103, 32'h0, 5'd8, 32'h48, 3, 32'h112233F0);
    issue(1, 0, 0, 0, 0, 2'b01, 2'b00, 32'h202, 32'hAAAABEEF, 5'd0, 32'h4C, 1, 0);
    issue(0, 1, 1, 0, 0, 2'b00, 2'b00, 32'h301, 32'h0, 5'd9, 32'h50, 1, 32'h55);
`ifdef MEM_TIMEOUT_EN
    issue(0, 1, 1, 0, 1, 2'b00, 2'b10, 32'h500, 32'h0, 5'd10, 32'h54, 0, 32'h1);
`endif

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      wr = (kind == 2);
      ld = (kind == 1);
      dly = $urandom_range(1, 4);
`ifdef MEM_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) dly = 0;
`endif
      issue(wr, ld, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
            $urandom, $urandom, 5'($urandom), $urandom, dly, $urandom);
    end
    issue(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0);
    repeat (3) @(negedge clk);
    chk("drain_random", expQ.size(), 0);

    // Reset in the middle of a long access; a later ack must be ignored.
    issue(0, 1, 1, 0, 1, 2'b00, 2'b00, 32'h400, 32'h0, 5'd3, 32'h60, 50, 32'hCAFE0000);
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_stall", stall, 1);
    monOn = 0;
    respOn = 0;
    rst_n = 0;
    @(negedge clk);
    #1;
    checkAllZero("midreset");
    dMemWr = 0; dMemToReg = 0; dRegWrite = 0; dJal = 0; dLoadext = 0;
    dDsize = 0; dFPoint = 0; dALUout = 0; dBusB = 0; dRw = 0; dDelayslot2 = 0;
    rst_n = 1;
    dmem_ack = 1;
    dmem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_stall", stall, 0);
      chk("late_ack_req", dmem_req, 0);
      chk("late_ack_MemData", MemData, 0);
    end
    dmem_ack = 0;
    expQ.delete();
    modelMemData = 0;
    respOn = 1;
    monOn = 1;

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      issue(kind == 2, kind == 1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
            $urandom, $urandom, 5'($urandom), $urandom, $urandom_range(1, 4), $urandom);
    end
    issue(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0);
    repeat (3) @(negedge clk);
    chk("drain_final", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time got 2000000 expected less");
    $fatal(1, "timeout");
  end
endmodule
